// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared state type and sizing for the shift-add multiply sequencer
package mul_pkg;

    localparam int MUL_WIDTH = 32;

    function automatic int cnt_w(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

    localparam int MUL_CNT_W = cnt_w(MUL_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/mul_step.sv
// rtl/mul_step.sv - one combinational radix-2 shift-add iteration
module mul_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] mcand,
    input  logic [WIDTH-1:0] mplr,
    output logic [WIDTH-1:0] next_acc,
    output logic [WIDTH-1:0] next_mcand,
    output logic [WIDTH-1:0] next_mplr,
    output logic             mplr_zero
);

    // Carry out of the add is dropped: only the low WIDTH product bits matter.
    assign next_acc   = mplr[0] ? (acc + mcand) : acc;
    assign next_mcand = {mcand[WIDTH-2:0], 1'b0};
    assign next_mplr  = {1'b0, mplr[WIDTH-1:1]};
    assign mplr_zero  = (next_mplr == '0);

endmodule

// File: rtl/mul_seq.sv
// rtl/mul_seq.sv - iterative MUL/MULS sequencer with N/Z flags; MUL_EARLY_TERM_EN stops once the multiplier is exhausted
module mul_seq
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             set_flags,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [1:0]       flag_nz,
    output logic             flag_we
);

    localparam int             CW       = cnt_w(WIDTH);
    localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

    mul_state_t       state_q, state_d;
    logic [WIDTH-1:0] acc_q, mcand_q, mplr_q, result_q;
    logic [CW-1:0]    cnt_q;
    logic             sf_q;

    logic [WIDTH-1:0] next_acc, next_mcand, next_mplr;
    logic             mplr_zero;
    logic             load, last_iter;

    mul_step #(.WIDTH(WIDTH)) u_step (
        .acc        (acc_q),
        .mcand      (mcand_q),
        .mplr       (mplr_q),
        .next_acc   (next_acc),
        .next_mcand (next_mcand),
        .next_mplr  (next_mplr),
        .mplr_zero  (mplr_zero)
    );

`ifdef MUL_EARLY_TERM_EN
    assign last_iter = (cnt_q == LAST_CNT) || mplr_zero;
`else
    logic unused_mplr_zero;
    assign unused_mplr_zero = mplr_zero;
    assign last_iter        = (cnt_q == LAST_CNT);
`endif

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (last_iter) state_d = DONE;
            end
            DONE: begin
                load    = start;
                state_d = start ? RUN : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplr_q   <= '0;
            cnt_q    <= '0;
            sf_q     <= 1'b0;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                acc_q   <= '0;
                mcand_q <= a;
                mplr_q  <= b;
                cnt_q   <= '0;
                sf_q    <= set_flags;
            end else if (state_q == RUN) begin
                acc_q   <= next_acc;
                mcand_q <= next_mcand;
                mplr_q  <= next_mplr;
                cnt_q   <= cnt_q + 1'b1;
            end
            // Result only moves on the final iteration so it holds through IDLE.
            if (state_q == RUN && last_iter) result_q <= next_acc;
        end
    end

    assign busy    = (state_q == RUN);
    assign done    = (state_q == DONE);
    assign result  = result_q;
    assign flag_nz = {result_q[WIDTH-1], (result_q == '0)};
    assign flag_we = done & sf_q;

endmodule

// File: tb/tb_mul_seq.sv
// tb/tb_mul_seq.sv - randomized self-checking bench for mul_seq against an arithmetic product/latency model
module tb_mul_seq;

    localparam int WIDTH = 32;

    logic             clk;
    logic             reset;
    logic             start;
    logic             set_flags;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [1:0]       flag_nz;
    logic             flag_we;

    int tests_run = 0;
    int fails     = 0;

    mul_seq #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .set_flags (set_flags),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .flag_nz   (flag_nz),
        .flag_we   (flag_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_prod(input logic [31:0] av, input logic [31:0] bv);
        logic [63:0] p;
        p = {32'd0, av} * {32'd0, bv};
        return p[31:0];
    endfunction

    // Cycles from the start edge to done: the multiplier's bit length (min 1) with early exit, else WIDTH.
    function automatic int ref_lat(input logic [31:0] bv);
`ifdef MUL_EARLY_TERM_EN
        int k;
        k = 1;
        for (int i = 0; i < 32; i++) if (bv[i]) k = i + 1;
        return k;
`else
        return (bv === 32'hx) ? 0 : WIDTH;
`endif
    endfunction

    task automatic start_op(input logic [31:0] av, input logic [31:0] bv, input logic sf);
        a         = av;
        b         = bv;
        set_flags = sf;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        a         = $urandom;
        b         = $urandom;
        set_flags = 1'($urandom);
    endtask

    task automatic wait_done(input logic [31:0] av, input logic [31:0] bv, input logic sf,
                             input string tag, input int poke_at);
        logic [31:0] p;
        int          k, lat, nbusy;
        logic        both;
        p     = ref_prod(av, bv);
        k     = ref_lat(bv);
        lat   = -1;
        nbusy = 0;
        both  = 1'b0;
        for (int c = 1; c <= WIDTH + 8; c++) begin
            if (busy && done) both = 1'b1;
            if (done) begin
                lat = c - 1;
                break;
            end
            if (busy) nbusy++;
            if (c == poke_at) begin
                start     = 1'b1;
                a         = $urandom;
                b         = $urandom;
                set_flags = ~sf;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, "_lat"},     64'(lat),   64'(k));
        check({tag, "_busy"},    64'(nbusy), 64'(k));
        check({tag, "_excl"},    64'(both),  64'(0));
        check({tag, "_result"},  64'(result), 64'(p));
        check({tag, "_nz"},      64'(flag_nz), 64'({p[31], p == 32'd0}));
        check({tag, "_flag_we"}, 64'(flag_we), 64'(sf));
    endtask

    task automatic after_done(input logic [31:0] av, input logic [31:0] bv, input string tag);
        @(negedge clk);
        check({tag, "_done_pulse"}, 64'(done),    64'(0));
        check({tag, "_we_pulse"},   64'(flag_we), 64'(0));
        check({tag, "_idle_busy"},  64'(busy),    64'(0));
        check({tag, "_hold"},       64'(result),  64'(ref_prod(av, bv)));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rb, na, nb;
        logic        rsf, nsf, chain, saw;

        reset = 1'b0; start = 1'b0; set_flags = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        check("rst_busy",    64'(busy),    64'(0));
        check("rst_done",    64'(done),    64'(0));
        check("rst_we",      64'(flag_we), 64'(0));
        check("rst_result",  64'(result),  64'(0));
        check("rst_nz",      64'(flag_nz), 64'(2'b01));
        reset = 1'b1;
        @(negedge clk);

        start_op(32'd3, 32'd5, 1'b0);
        wait_done(32'd3, 32'd5, 1'b0, "small", -1);
        after_done(32'd3, 32'd5, "small");

        start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        wait_done(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "ones", -1);
        after_done(32'hFFFF_FFFF, 32'hFFFF_FFFF, "ones");

        start_op(32'h1234, 32'd0, 1'b1);
        wait_done(32'h1234, 32'd0, 1'b1, "zero_b", -1);
        after_done(32'h1234, 32'd0, "zero_b");

        start_op(32'd7, 32'd6, 1'b0);
        wait_done(32'd7, 32'd6, 1'b0, "b2b_first", -1);
        start_op(32'd2, 32'h8000_0000, 1'b1);
        wait_done(32'd2, 32'h8000_0000, 1'b1, "b2b_second", -1);
        after_done(32'd2, 32'h8000_0000, "b2b_second");

        start_op(32'd11, 32'h9000_0001, 1'b1);
        wait_done(32'd11, 32'h9000_0001, 1'b1, "restart_ignored", 10);
        after_done(32'd11, 32'h9000_0001, "restart_ignored");

        start_op(32'd5, 32'd9, 1'b0);
        wait_done(32'd5, 32'd9, 1'b0, "pre_reset", -1);
        after_done(32'd5, 32'd9, "pre_reset");

        start_op(32'hABCD, 32'h8001_0000, 1'b1);
        repeat (4) @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrun_busy",   64'(busy),    64'(0));
        check("midrun_done",   64'(done),    64'(0));
        check("midrun_result", 64'(result),  64'(0));
        check("midrun_nz",     64'(flag_nz), 64'(2'b01));
        check("midrun_we",     64'(flag_we), 64'(0));
        repeat (2) @(negedge clk);
        reset = 1'b1;
        saw = 1'b0;
        for (int c = 0; c < WIDTH + 4; c++) begin
            @(negedge clk);
            if (done || busy) saw = 1'b1;
        end
        check("post_reset_quiet", 64'(saw), 64'(0));

        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        start_op(32'd100, 32'd200, 1'b1);
        wait_done(32'd100, 32'd200, 1'b1, "release_start", -1);
        after_done(32'd100, 32'd200, "release_start");

        chain = 1'b0;
        ra = $urandom; rb = $urandom >> $urandom_range(0, 31); rsf = 1'($urandom);
        for (int i = 0; i < 10; i++) begin
            if (!chain) start_op(ra, rb, rsf);
            wait_done(ra, rb, rsf, $sformatf("rand%0d", i), -1);
            na    = $urandom;
            nb    = ($urandom_range(0, 3) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
            nsf   = 1'($urandom);
            chain = (i < 9) && ($urandom_range(0, 1) == 1);
            if (chain) start_op(na, nb, nsf);
            else       after_done(ra, rb, $sformatf("rand%0d", i));
            ra = na; rb = nb; rsf = nsf;
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
